spi_slave_word_link: RTL and testbench

- Bit-level SPI slave front end that sits directly upstream of the SPI processing unit's receive buffer and directly downstream of its send buffer.
- Oversamples the external SPI pins in the system clock domain.
- Assembles MOSI bits into DATA_WIDTH-bit words and serialises queued words onto MISO.
- Hands complete words to the buffers through a valid/ready-style interface.

---
 rtl/spi_slave_word_link.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_slave_word_link.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_word_link.sv
// spi_slave_word_link
// Bit-level SPI (mode 0) slave front end. The SPI pins are oversampled in the
// clk domain. MOSI bits are assembled into DATA_WIDTH-bit words, and words from
// a single-entry holding register are serialised MSB first onto MISO.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-low reset
//   sclk          SPI clock from master (mode 0, idles low)
//   cs            chip select, active-low
//   mosi          master-out data, MSB first
//   miso          slave-out data, MSB first (0 while idle, never tri-stated)
//   tx_data       next word to transmit
//   tx_valid      tx_data valid; accepted when tx_valid & tx_ready
//   tx_ready      holding register empty
//   rx_data       last completed received word
//   rx_valid      one-cycle pulse when rx_data updates
//   byte_done     one-cycle pulse after every SPI_DATA_WIDTH received bits
//   tx_underflow  one-cycle pulse when a word load finds the holding register empty
//   frame_error   one-cycle pulse when cs deasserts mid-word
//   busy          synchronised cs is low
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no frame in progress; waits for an armed cs falling edge
// ST_SHIFT | frame active; sampling on sclk rise, shifting on sclk fall

module spi_slave_word_link #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  byte_done,
    output logic                  tx_underflow,
    output logic                  frame_error,
    output logic                  busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam int CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int BCNT_W = (SPI_DATA_WIDTH > 1) ? $clog2(SPI_DATA_WIDTH) : 1;
    localparam int HO_W   = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_fall;
    logic                   cs_rise;

    logic [HO_W-1:0]        holdoff;
    logic                   armed;

    logic [0:0]             state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [BCNT_W-1:0]      byte_cnt;
    logic [DATA_WIDTH-2:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  rx_next;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic                   skip_fall;

    logic [DATA_WIDTH-1:0]  hold_data;
    logic                   hold_full;

    logic                   word_last;
    logic                   byte_last;
    logic                   start_frame;
    logic                   word_end;
    logic                   load_tx;
    logic [DATA_WIDTH-1:0]  tx_load_val;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // The cs synchroniser is preset high, so right after reset it shows a
    // fake high level for SYNC_STAGES cycles. A frame may only start once a
    // genuine cs high has been seen, i.e. after the preset has flushed out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            holdoff <= HO_W'(SYNC_STAGES);
            armed   <= 1'b0;
        end else if (holdoff != '0) begin
            holdoff <= holdoff - HO_W'(1);
        end else if (cs_s) begin
            armed   <= 1'b1;
        end
    end

    assign word_last   = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign byte_last   = (byte_cnt == BCNT_W'(SPI_DATA_WIDTH - 1));
    assign rx_next     = {rx_shift, mosi_s};
    assign start_frame = (state == ST_IDLE) && cs_fall && armed;
    assign word_end    = (state == ST_SHIFT) && !cs_rise && sclk_rise && word_last;
    assign load_tx     = start_frame || word_end;
    assign tx_load_val = hold_full ? hold_data : '0;

    // A write can only land while empty, so a same-cycle load never clears a
    // freshly written word; a load of a full register frees it for next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (tx_valid && !hold_full) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
        end else if (load_tx) begin
            hold_full <= 1'b0;
        end
    end

    assign tx_ready = ~hold_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            skip_fall    <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            byte_done    <= 1'b0;
            tx_underflow <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            byte_done    <= 1'b0;
            frame_error  <= 1'b0;
            tx_underflow <= load_tx && !hold_full;
            case (state)
                ST_IDLE: begin
                    if (start_frame) begin
                        state     <= ST_SHIFT;
                        bit_cnt   <= '0;
                        byte_cnt  <= '0;
                        rx_shift  <= '0;
                        tx_shift  <= tx_load_val;
                        skip_fall <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        state       <= ST_IDLE;
                        frame_error <= (bit_cnt != '0);
                        bit_cnt     <= '0;
                        byte_cnt    <= '0;
                        tx_shift    <= '0;
                        skip_fall   <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift  <= rx_next[DATA_WIDTH-2:0];
                        byte_done <= byte_last;
                        byte_cnt  <= byte_last ? '0 : byte_cnt + BCNT_W'(1);
                        bit_cnt   <= word_last ? '0 : bit_cnt + CNT_W'(1);
                        if (word_last) begin
                            rx_data   <= rx_next;
                            rx_valid  <= 1'b1;
                            tx_shift  <= tx_load_val;
                            // The next word's MSB is already on miso; the
                            // falling edge that follows must not shift it away.
                            skip_fall <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (skip_fall) begin
                            skip_fall <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign miso = (state == ST_SHIFT) & tx_shift[DATA_WIDTH-1];
    assign busy = ~cs_s;

endmodule

// File: tb/tb_spi_slave_word_link.sv
module tb_spi_slave_word_link;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        miso;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        byte_done;
    logic        tx_underflow;
    logic        frame_error;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    int rx_cnt = 0;
    int bd_cnt = 0;
    int uf_cnt = 0;
    int fe_cnt = 0;
    logic [31:0] rx_log [0:15];

    logic [31:0] mosi_w [0:3];
    logic [31:0] miso_w [0:3];

    int r0, b0, u0, f0;

    spi_slave_word_link dut (
        .clk          (clk),
        .rst          (rst),
        .sclk         (sclk),
        .cs           (cs),
        .mosi         (mosi),
        .miso         (miso),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .byte_done    (byte_done),
        .tx_underflow (tx_underflow),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[4'(rx_cnt)] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (byte_done)    bd_cnt <= bd_cnt + 1;
        if (tx_underflow) uf_cnt <= uf_cnt + 1;
        if (frame_error)  fe_cnt <= fe_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [31:0] d);
        logic ok;
        ok = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (tx_ready) ok = 1'b1;
            tick(1);
        end
        tx_valid = 1'b0;
        check("tx_handshake", 32'(ok), 32'd1);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(8);
    endtask

    task automatic cs_high();
        tick(HALF);
        cs = 1'b1;
        tick(12);
    endtask

    // Mode 0 master: mosi set while sclk low, miso sampled just before the rise.
    task automatic bits(input int n);
        logic [1:0] w;
        logic [4:0] b;
        for (int i = 0; i < n; i++) begin
            w = 2'(i / 32);
            b = 5'(31 - (i % 32));
            mosi = mosi_w[w][b];
            tick(HALF);
            miso_w[w][b] = miso;
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input int n);
        cs_low();
        bits(n);
        cs_high();
    endtask

    task automatic snap();
        r0 = rx_cnt;
        b0 = bd_cnt;
        u0 = uf_cnt;
        f0 = fe_cnt;
    endtask

    initial begin
        // reset state
        tick(3);
        check("rst_miso",      32'(miso), 32'd0);
        check("rst_rx_data",   rx_data, 32'h0);
        check("rst_rx_valid",  32'(rx_valid), 32'd0);
        check("rst_tx_ready",  32'(tx_ready), 32'd1);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_underflow", 32'(tx_underflow), 32'd0);
        rst = 1'b1;
        tick(10);

        // single word
        snap();
        push_tx(32'hB1B2B3B4);
        mosi_w[0] = 32'hA1A2A3A4;
        frame(32);
        check("t1_rx_count",  32'(rx_cnt - r0), 32'd1);
        check("t1_rx_word",   rx_log[4'(r0)], 32'hA1A2A3A4);
        check("t1_rx_data",   rx_data, 32'hA1A2A3A4);
        check("t1_miso_word", miso_w[0], 32'hB1B2B3B4);
        check("t1_byte_done", 32'(bd_cnt - b0), 32'd4);
        check("t1_frame_err", 32'(fe_cnt - f0), 32'd0);
        // holding empty at the end-of-word reload
        check("t1_underflow", 32'(uf_cnt - u0), 32'd1);

        // back-to-back words in one frame
        snap();
        push_tx(32'h11111111);
        mosi_w[0] = 32'hC1C2C3C4;
        mosi_w[1] = 32'hD1D2D3D4;
        fork
            frame(64);
            push_tx(32'h22222222);
        join
        check("t2_rx_count", 32'(rx_cnt - r0), 32'd2);
        check("t2_rx_word0", rx_log[4'(r0)], 32'hC1C2C3C4);
        check("t2_rx_word1", rx_log[4'(r0 + 1)], 32'hD1D2D3D4);
        check("t2_miso0",    miso_w[0], 32'h11111111);
        check("t2_miso1",    miso_w[1], 32'h22222222);
        check("t2_byte_done", 32'(bd_cnt - b0), 32'd8);
        check("t2_underflow", 32'(uf_cnt - u0), 32'd1);

        // underflow
        snap();
        mosi_w[0] = 32'h12345678;
        cs_low();
        check("t3_uf_at_cs_fall", 32'(uf_cnt - u0), 32'd1);
        check("t3_busy", 32'(busy), 32'd1);
        bits(32);
        cs_high();
        check("t3_miso_word", miso_w[0], 32'h00000000);
        check("t3_rx_data",   rx_data, 32'h12345678);
        check("t3_underflow", 32'(uf_cnt - u0), 32'd2);
        check("t3_busy_idle", 32'(busy), 32'd0);

        // aborted frame after 13 bits
        snap();
        mosi_w[0] = 32'hFFFFFFFF;
        frame(13);
        check("t4_frame_err", 32'(fe_cnt - f0), 32'd1);
        check("t4_rx_count",  32'(rx_cnt - r0), 32'd0);
        check("t4_rx_kept",   rx_data, 32'h12345678);
        check("t4_byte_done", 32'(bd_cnt - b0), 32'd1);
        snap();
        mosi_w[0] = 32'hA2A2A3A4;
        frame(32);
        check("t4_next_rx",   rx_data, 32'hA2A2A3A4);
        check("t4_next_count", 32'(rx_cnt - r0), 32'd1);
        check("t4_next_ferr", 32'(fe_cnt - f0), 32'd0);

        // write presented while the holding register is being reloaded
        snap();
        push_tx(32'h5A5A5A5A);
        mosi_w[0] = 32'h01020304;
        mosi_w[1] = 32'h05060708;
        mosi_w[2] = 32'h090A0B0C;
        fork
            frame(96);
            begin
                push_tx(32'h3C3C3C3C);
                push_tx(32'h96969696);
            end
        join
        check("t5_miso0", miso_w[0], 32'h5A5A5A5A);
        check("t5_miso1", miso_w[1], 32'h3C3C3C3C);
        check("t5_miso2", miso_w[2], 32'h96969696);
        check("t5_rx_count", 32'(rx_cnt - r0), 32'd3);
        check("t5_rx_word2", rx_log[4'(r0 + 2)], 32'h090A0B0C);
        check("t5_underflow", 32'(uf_cnt - u0), 32'd1);

        // async reset mid-word
        push_tx(32'hFFFFFFFF);
        mosi_w[0] = 32'h0;
        cs_low();
        push_tx(32'h0F0F0F0F);
        bits(20);
        tick(HALF);
        check("t6_pre_miso",     32'(miso), 32'd1);
        check("t6_pre_tx_ready", 32'(tx_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("t6_miso",      32'(miso), 32'd0);
        check("t6_rx_data",   rx_data, 32'h0);
        check("t6_rx_valid",  32'(rx_valid), 32'd0);
        check("t6_byte_done", 32'(byte_done), 32'd0);
        check("t6_underflow", 32'(tx_underflow), 32'd0);
        check("t6_frame_err", 32'(frame_error), 32'd0);
        check("t6_busy",      32'(busy), 32'd0);
        check("t6_tx_ready",  32'(tx_ready), 32'd1);
        tick(3);
        rst = 1'b1;
        tick(10);
        // cs still low: the block must ignore this traffic
        snap();
        mosi_w[0] = 32'hFFFFFFFF;
        bits(32);
        check("t6_no_word",   32'(rx_cnt - r0), 32'd0);
        check("t6_no_bytes",  32'(bd_cnt - b0), 32'd0);
        check("t6_no_uf",     32'(uf_cnt - u0), 32'd0);
        check("t6_idle_miso", miso_w[0], 32'h0);
        cs_high();
        check("t6_no_ferr",   32'(fe_cnt - f0), 32'd0);
        snap();
        mosi_w[0] = 32'h5555AAAA;
        frame(32);
        check("t6_after_rx",    rx_data, 32'h5555AAAA);
        check("t6_after_count", 32'(rx_cnt - r0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
